// File: rtl/uart_rx.sv
// uart_rx: UART receive front end. Midpoint-samples 5-8 bit characters with optional
// parity and 1 or 2 stop bits, and presents them on a valid/ready port with error pulses.
`timescale 1ns/1ps
module uart_rx #(
   parameter int unsigned MIN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_i,
   input  logic [15:0] cfg_baud_div,
   input  logic [1:0]  cfg_data_bits,
   input  logic        cfg_parity_en,
   input  logic        cfg_parity_odd,
   input  logic        cfg_stop2,
   input  logic        rx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        parity_error,
   output logic        frame_error,
   output logic [3:0]  err_id,
   output logic        busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

   logic        sync1_q, sync2_q, prev_q;
   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  last_bit_q, last_bit_d;
   logic        par_en_q, par_en_d;
   logic        par_odd_q, par_odd_d;
   logic        stop2_q, stop2_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_err_q, par_err_d;
   logic        stop_err_q, stop_err_d;
   logic        zero_q, zero_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        perr_pulse_q, perr_pulse_d;
   logic        ferr_pulse_q, ferr_pulse_d;
   logic [3:0]  err_id_q, err_id_d;

   logic        sample;
   logic        expire;
   logic        complete;
   logic        brk;
   logic        ovr;
   logic [7:0]  bit_wr;

   assign sample = sync2_q;

   // One-hot write strobe for the data bit currently being sampled.
   for (genvar gi = 0; gi < 8; gi++) begin : g_bit_wr
      assign bit_wr[gi] = (bit_idx_q == 3'(gi));
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      last_bit_d   = last_bit_q;
      par_en_d     = par_en_q;
      par_odd_d    = par_odd_q;
      stop2_d      = stop2_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_err_d    = par_err_q;
      stop_err_d   = stop_err_q;
      zero_d       = zero_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q & ~rx_ready;
      perr_pulse_d = 1'b0;
      ferr_pulse_d = 1'b0;
      err_id_d     = 4'd0;
      complete     = 1'b0;
      brk          = 1'b0;
      ovr          = 1'b0;
      expire       = (cnt_q <= 16'd1);

      if (state_q != ST_IDLE) begin
         cnt_d = cnt_q - 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (!sync2_q && prev_q) begin
               div_d      = (cfg_baud_div < MIN_DIV_W) ? MIN_DIV_W : cfg_baud_div;
               cnt_d      = div_d >> 1;
               // Index of the final data bit: 5..8 bits map to 4..7.
               last_bit_d = {1'b1, cfg_data_bits};
               par_en_d   = cfg_parity_en;
               par_odd_d  = cfg_parity_odd;
               stop2_d    = cfg_stop2;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (expire) begin
               if (sample) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d      = div_q;
                  bit_idx_d  = 3'd0;
                  shift_d    = 8'd0;
                  par_err_d  = 1'b0;
                  stop_err_d = 1'b0;
                  zero_d     = 1'b1;
                  state_d    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (expire) begin
               cnt_d     = div_q;
               shift_d   = (shift_q & ~bit_wr) | (bit_wr & {8{sample}});
               zero_d    = zero_q & ~sample;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == last_bit_q) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP1;
               end
            end
         end
         ST_PARITY: begin
            if (expire) begin
               cnt_d     = div_q;
               par_err_d = sample ^ (^shift_q) ^ par_odd_q;
               zero_d    = zero_q & ~sample;
               state_d   = ST_STOP1;
            end
         end
         ST_STOP1: begin
            if (expire) begin
               cnt_d      = div_q;
               stop_err_d = ~sample;
               zero_d     = zero_q & ~sample;
               if (stop2_q) begin
                  state_d = ST_STOP2;
               end else begin
                  complete = 1'b1;
               end
            end
         end
         ST_STOP2: begin
            if (expire) begin
               stop_err_d = stop_err_q | ~sample;
               zero_d     = zero_q & ~sample;
               complete   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A break (every sampled bit low) reports instead of delivering data; overrun
      // only applies when a real character would have been pushed.
      if (complete) begin
         state_d      = ST_IDLE;
         brk          = zero_d;
         ovr          = ~brk & rx_valid_q & ~rx_ready;
         perr_pulse_d = par_err_q;
         ferr_pulse_d = stop_err_d;
         err_id_d     = {ovr, brk, stop_err_d, par_err_q};
         if (!brk && !ovr) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= 16'd0;
         div_q        <= 16'd0;
         last_bit_q   <= 3'd0;
         par_en_q     <= 1'b0;
         par_odd_q    <= 1'b0;
         stop2_q      <= 1'b0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'd0;
         par_err_q    <= 1'b0;
         stop_err_q   <= 1'b0;
         zero_q       <= 1'b0;
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         perr_pulse_q <= 1'b0;
         ferr_pulse_q <= 1'b0;
         err_id_q     <= 4'd0;
      end else begin
         sync1_q      <= rx_i;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         last_bit_q   <= last_bit_d;
         par_en_q     <= par_en_d;
         par_odd_q    <= par_odd_d;
         stop2_q      <= stop2_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_err_q    <= par_err_d;
         stop_err_q   <= stop_err_d;
         zero_q       <= zero_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         perr_pulse_q <= perr_pulse_d;
         ferr_pulse_q <= ferr_pulse_d;
         err_id_q     <= err_id_d;
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign parity_error = perr_pulse_q;
   assign frame_error  = ferr_pulse_q;
   assign err_id       = err_id_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
